// File: rtl/hazard_fwd_ctl.sv
// rtl/hazard_fwd_ctl.sv - scoreboard hazard detection, load-use stall, branch flush and EX forwarding
// Define HZ_FWD_EN for full forwarding; when it is undefined the block is interlock-only (selects tied to 0).
module hazard_fwd_ctl #(
  parameter int RADDR_WIDTH  = 5,
  parameter int FWD_STAGES   = 3,
  parameter int LOAD_LAT     = 1,
  parameter int BR_STAGE     = 2,
  parameter int FLUSH_CYCLES = 2,
  localparam int SEL_W       = $clog2(FWD_STAGES + 1)
) (
  input  logic                   clk_87,
  input  logic                   rst_87,
  input  logic                   id_valid_87,
  input  logic [RADDR_WIDTH-1:0] id_rs_87,
  input  logic [RADDR_WIDTH-1:0] id_rt_87,
  input  logic                   id_rs_used_87,
  input  logic                   id_rt_used_87,
  input  logic [RADDR_WIDTH-1:0] id_wreg_87,
  input  logic                   id_reg_write_87,
  input  logic                   id_is_load_87,
  input  logic                   branch_taken_87,
  input  logic                   mem_wait_87,
  output logic                   stall_87,
  output logic                   flush_87,
  output logic [SEL_W-1:0]       fwd_a_sel_87,
  output logic [SEL_W-1:0]       fwd_b_sel_87
);

`ifdef HZ_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Forwarding only has to cover loads too young to forward; interlock must wait for WB.
  localparam int STALL_WIN = FWD_EN ? LOAD_LAT : (FWD_STAGES - 1);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  logic [FWD_STAGES-1:0]                  sb_valid_q, sb_valid_d;
  logic [FWD_STAGES-1:0]                  sb_load_q, sb_load_d;
  logic [FWD_STAGES-1:0][RADDR_WIDTH-1:0] sb_rd_q, sb_rd_d;
  logic [CNT_W-1:0]                       flush_cnt_q, flush_cnt_d;
  logic                                   br_pend_q, br_pend_d;

  logic [FWD_STAGES-1:0] match_a, match_b;
  logic [SEL_W-1:0]      sel_a, sel_b;
  logic                  hz_stall;
  logic                  flush_raw;
  logic                  stall_raw;
  logic                  br_apply;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      match_a[k] = sb_valid_q[k] && id_rs_used_87 && (id_rs_87 != '0) && (sb_rd_q[k] == id_rs_87);
      match_b[k] = sb_valid_q[k] && id_rt_used_87 && (id_rt_87 != '0) && (sb_rd_q[k] == id_rt_87);
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (match_a[k]) sel_a = SEL_W'(k + 1);
      if (match_b[k]) sel_b = SEL_W'(k + 1);
    end
  end

  always_comb begin
    hz_stall = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if ((k < STALL_WIN) && (match_a[k] || match_b[k]) && (sb_load_q[k] || !FWD_EN)) begin
        hz_stall = 1'b1;
      end
    end
  end

  // A branch parked during a freeze keeps flush asserted until it is applied.
  assign flush_raw = branch_taken_87 | br_pend_q | (flush_cnt_q != '0);
  assign stall_raw = mem_wait_87 | (hz_stall & ~flush_raw);

  assign stall_87     = rst_87 & stall_raw;
  assign flush_87     = rst_87 & flush_raw;
  assign fwd_a_sel_87 = (FWD_EN && rst_87) ? sel_a : '0;
  assign fwd_b_sel_87 = (FWD_EN && rst_87) ? sel_b : '0;

  always_comb begin
    sb_valid_d  = sb_valid_q;
    sb_load_d   = sb_load_q;
    sb_rd_d     = sb_rd_q;
    flush_cnt_d = flush_cnt_q;
    br_pend_d   = br_pend_q;
    br_apply    = branch_taken_87 | br_pend_q;
    if (mem_wait_87) begin
      br_pend_d = br_pend_q | branch_taken_87;
    end else begin
      br_pend_d = 1'b0;
      // Instructions younger than the resolving branch are squashed as they shift.
      for (int k = 1; k < FWD_STAGES; k++) begin
        sb_valid_d[k] = sb_valid_q[k-1] && !(br_apply && ((k - 1) < BR_STAGE));
        sb_load_d[k]  = sb_load_q[k-1];
        sb_rd_d[k]    = sb_rd_q[k-1];
      end
      sb_valid_d[0] = id_valid_87 & id_reg_write_87 & (id_wreg_87 != '0) & ~stall_raw & ~flush_raw;
      sb_load_d[0]  = id_is_load_87;
      sb_rd_d[0]    = id_wreg_87;
      if (br_apply) begin
        flush_cnt_d = CNT_RELOAD;
      end else if (flush_cnt_q != '0) begin
        flush_cnt_d = flush_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_87 or negedge rst_87) begin
    if (!rst_87) begin
      sb_valid_q  <= '0;
      sb_load_q   <= '0;
      sb_rd_q     <= '0;
      flush_cnt_q <= '0;
      br_pend_q   <= 1'b0;
    end else begin
      sb_valid_q  <= sb_valid_d;
      sb_load_q   <= sb_load_d;
      sb_rd_q     <= sb_rd_d;
      flush_cnt_q <= flush_cnt_d;
      br_pend_q   <= br_pend_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctl.sv
// tb/tb_hazard_fwd_ctl.sv - scoreboard-checked bench for hazard_fwd_ctl
// Expectations follow HZ_FWD_EN when it is defined for the build.
module tb_hazard_fwd_ctl;

`ifdef HZ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk_87 = 1'b0;
  logic       rst_87;
  logic       id_valid_87, id_rs_used_87, id_rt_used_87, id_reg_write_87, id_is_load_87;
  logic [4:0] id_rs_87, id_rt_87, id_wreg_87;
  logic       branch_taken_87, mem_wait_87;
  logic       stall_87, flush_87;
  logic [1:0] fwd_a_sel_87, fwd_b_sel_87;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic [4:0] wr;
    logic       rw;
    logic       ld;
    logic       br;
    logic       mw;
    logic [5:0] exp;
  } row_t;

  row_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  hazard_fwd_ctl dut (
    .clk_87          (clk_87),
    .rst_87          (rst_87),
    .id_valid_87     (id_valid_87),
    .id_rs_87        (id_rs_87),
    .id_rt_87        (id_rt_87),
    .id_rs_used_87   (id_rs_used_87),
    .id_rt_used_87   (id_rt_used_87),
    .id_wreg_87      (id_wreg_87),
    .id_reg_write_87 (id_reg_write_87),
    .id_is_load_87   (id_is_load_87),
    .branch_taken_87 (branch_taken_87),
    .mem_wait_87     (mem_wait_87),
    .stall_87        (stall_87),
    .flush_87        (flush_87),
    .fwd_a_sel_87    (fwd_a_sel_87),
    .fwd_b_sel_87    (fwd_b_sel_87)
  );

  always #5 clk_87 = ~clk_87;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int fs(input int s);
    return FWD ? s : 0;
  endfunction

  function automatic int st(input int f, input int i);
    return FWD ? f : i;
  endfunction

  function automatic row_t mk(input int v, input int rs, input int rsu, input int rt, input int rtu,
                              input int wr, input int rw, input int ld, input int br, input int mw,
                              input int es, input int ef, input int ea, input int eb);
    row_t r;
    r.v   = (v != 0);
    r.rs  = 5'(rs);
    r.rsu = (rsu != 0);
    r.rt  = 5'(rt);
    r.rtu = (rtu != 0);
    r.wr  = 5'(wr);
    r.rw  = (rw != 0);
    r.ld  = (ld != 0);
    r.br  = (br != 0);
    r.mw  = (mw != 0);
    r.exp = {es != 0, ef != 0, 2'(fs(ea)), 2'(fs(eb))};
    return r;
  endfunction

  task automatic drive(input row_t r);
    id_valid_87     = r.v;
    id_rs_87        = r.rs;
    id_rs_used_87   = r.rsu;
    id_rt_87        = r.rt;
    id_rt_used_87   = r.rtu;
    id_wreg_87      = r.wr;
    id_reg_write_87 = r.rw;
    id_is_load_87   = r.ld;
    branch_taken_87 = r.br;
    mem_wait_87     = r.mw;
    exp_q.push_back(r);
  endtask

  task automatic drain();
    id_valid_87 = 0; id_rs_87 = 0; id_rt_87 = 0; id_rs_used_87 = 0; id_rt_used_87 = 0;
    id_wreg_87 = 0; id_reg_write_87 = 0; id_is_load_87 = 0; branch_taken_87 = 0; mem_wait_87 = 0;
    repeat (3) @(posedge clk_87);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    rst_87 = 1'b0;
    rows.push_back(mk(1, 3, 1, 3, 1, 3, 1, 0, 1, 1, 0, 0, 0, 0));
    rows.push_back(mk(1, 3, 1, 3, 1, 3, 1, 0, 1, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      if (i == 2) rst_87 = 1'b1;
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  task automatic test_fwd_alu();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 3, 1, 4, 1, 6, 1, 0, 0, 0, st(0, 1), 0, 1, 0));
    rows.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, st(0, 1), 0, 2, 0));
    rows.push_back(mk(0, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3));
    foreach (rows[i]) begin
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL fwd_alu[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 5, 1, 8, 1, 0, 0, 0, 1, 0, 0, 1));
    rows.push_back(mk(1, 1, 1, 5, 1, 8, 1, 0, 0, 0, st(0, 1), 0, 0, 2));
    rows.push_back(mk(0, 8, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    foreach (rows[i]) begin
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL load_use[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  task automatic test_r0_and_youngest();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 4, 1, 9, 1, 0, 0, 0, 0, 0, st(0, 1), 0, 1, 2));
    foreach (rows[i]) begin
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL r0_youngest[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 1, 3, 1, 12, 1, 0, 1, 0, 0, 1, 3, 1));
    rows.push_back(mk(1, 2, 1, 3, 1, 13, 1, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(mk(0, 12, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL branch[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  task automatic test_mem_wait();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 5, 1, 8, 1, 0, 0, 1, 1, 0, 0, 1));
    rows.push_back(mk(1, 0, 0, 5, 1, 8, 1, 0, 1, 1, 1, 1, 0, 1));
    rows.push_back(mk(1, 0, 0, 5, 1, 8, 1, 0, 0, 1, 1, 1, 0, 1));
    rows.push_back(mk(1, 0, 0, 5, 1, 8, 1, 0, 0, 0, 0, 1, 0, 1));
    rows.push_back(mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(mk(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL mem_wait[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  task automatic test_midreset();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 9, 1, 10, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 9, 1, 10, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 9, 1, 11, 1, 0, 0, 0, 0, 0, st(0, 1), 0, 0, 1));
    foreach (rows[i]) begin
      if (i == 2) rst_87 = 1'b0;
      if (i == 3) rst_87 = 1'b1;
      drive(rows[i]);
      #3;
      e = exp_q.pop_front();
      n_checks++;
      if ({stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87} !== e.exp) begin
        n_fail++;
        $display("FAIL midreset[%0d]: stall,flush,a,b got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                 stall_87, flush_87, fwd_a_sel_87, fwd_b_sel_87, e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
      end
      @(posedge clk_87);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_fwd_alu();
    drain();
    test_load_use();
    drain();
    test_r0_and_youngest();
    drain();
    test_branch();
    drain();
    test_back_to_back();
    drain();
    test_mem_wait();
    drain();
    test_midreset();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctl.md
# hazard_fwd_ctl

Parametrised hazard-detection and forwarding controller for the 5-stage MIPS pipeline. It replaces the fixed-stage hazard unit and keeps its own registered scoreboard of in-flight destination registers. From that scoreboard it produces the per-operand forwarding mux selects, load-use stalls, multi-cycle branch flushes and a global memory-wait freeze. It sits beside the ID stage, takes source/destination fields from decode and the taken-branch flag from the data-memory stage, and drives the IF/ID stall and flush controls and the EX operand muxes.

## Interface
Parameters:
- RADDR_WIDTH, 5, register-address width.
- FWD_STAGES, 3, tracked stages past ID (EX, MEM, WB); also the number of forwarding sources.
- LOAD_LAT, 1, stages after ID in which a load result is not yet forwardable (1..FWD_STAGES-1).
- BR_STAGE, 2, scoreboard index where branches resolve; entries 0..BR_STAGE-1 are squashed on a taken branch.
- FLUSH_CYCLES, 2, cycles `flush_87` stays asserted per taken branch (≥1).

Ports:
- clk_87 in 1: clock, rising edge.
- rst_87 in 1: asynchronous, active-low reset.
- id_valid_87 in 1: ID holds a real instruction.
- id_rs_87 in RADDR_WIDTH: ID source register A.
- id_rt_87 in RADDR_WIDTH: ID source register B.
- id_rs_used_87 in 1: source A is read.
- id_rt_used_87 in 1: source B is read.
- id_wreg_87 in RADDR_WIDTH: ID destination register.
- id_reg_write_87 in 1: ID instruction writes the register file.
- id_is_load_87 in 1: ID instruction is a load.
- branch_taken_87 in 1: branch resolved taken (single-cycle pulse).
- mem_wait_87 in 1: data memory busy; freeze the pipeline.
- stall_87 out 1: hold PC and IF/ID; insert a bubble into EX.
- flush_87 out 1: squash IF/ID contents.
- fwd_a_sel_87 out SEL_W: operand A source. 0 = register file; k = scoreboard stage k-1. SEL_W = $clog2(FWD_STAGES+1).
- fwd_b_sel_87 out SEL_W: operand B source, same encoding.

## Operation
- Scoreboard: FWD_STAGES entries {valid, rd, is_load}. Entry 0 is youngest (EX); entry FWD_STAGES-1 is oldest (WB).
- Each unfrozen clock edge:
  - entry[k] <= entry[k-1].
  - entry[0] <= {id_valid & id_reg_write & (id_wreg != 0) & !stall & !flush, id_wreg, id_is_load}.
- Match for a source: entry valid, rd equal to the source, and source used. A source of r0 never matches.
- Forward select: the lowest matching k gives sel = k+1; no match gives sel = 0. Both operands are evaluated independently.
- Load-use: `stall_87` = 1 when a matching entry k has is_load and k < LOAD_LAT. Because the stalled instruction stays in ID and a bubble enters entry 0, the stall releases naturally after LOAD_LAT-k cycles.
- Taken branch:
  - `flush_87` is high in the `branch_taken_87` cycle.
  - A down-counter keeps it high for FLUSH_CYCLES-1 further cycles.
  - At the edge, entries 0..BR_STAGE-1 are cleared to invalid and shifting continues.
- Priority: reset > `mem_wait_87` > `branch_taken_87`/flush > stall.
  - `stall_87` is forced 0 while `flush_87` = 1.
- Freeze (`mem_wait_87` = 1): the scoreboard and flush counter hold; `stall_87` = 1; selects are recomputed from the held state.
- A `branch_taken_87` that arrives during a freeze is latched and applied on the first unfrozen edge.
- A new `branch_taken_87` while the counter is nonzero reloads the counter to FLUSH_CYCLES-1.

## Timing
- Selects and `stall_87` are combinational from the current ID inputs and the registered scoreboard; they are valid in the same cycle.
- `flush_87` is combinational on `branch_taken_87` OR (counter ≠ 0).
- Scoreboard latency: an ID instruction becomes forwardable as sel=1 in the next cycle, sel=2 two cycles later, and so on. It retires after FWD_STAGES edges.
- Reset (`rst_87` low, asynchronous):
  - all entries invalid, counter 0, latched branch 0;
  - `stall_87`, `flush_87`, `fwd_a_sel_87` and `fwd_b_sel_87` forced 0 while low.
- Reset deassertion mid-stream: the first edge after release loads entry 0 from the ID inputs. No stale hazards remain.

## Configuration
- HZ_FWD_EN defined: full forwarding as described.
- HZ_FWD_EN undefined (interlock-only):
  - `fwd_a_sel_87` and `fwd_b_sel_87` are tied to 0;
  - any match in entries 0..FWD_STAGES-2 asserts `stall_87`, regardless of is_load. A match in the WB entry does not stall because the register file writes first-half.

## Test plan
- `add r3` then `sub` with rs=r3 on consecutive cycles -> second cycle fwd_a_sel=1, stall=0; next cycle (if still reading r3) sel=2.
- `lw r5` then `add` with rt=r5, LOAD_LAT=1 -> stall=1 for exactly 1 cycle, then fwd_b_sel=2, stall=0.
- Write to r0 followed by a read of r0 -> both selects stay 0, no stall.
- Matches in entries 0 and 2 for rs -> fwd_a_sel=1 (youngest wins).
- `branch_taken` pulse with FLUSH_CYCLES=2 and entries 0,1 valid -> flush high 2 cycles; entries 0,1 invalid; entry 2 still forwards.
- `mem_wait` held 3 cycles during a load-use -> scoreboard unchanged; stall=1 throughout; `branch_taken` pulsed mid-wait gives flush after release. With HZ_FWD_EN undefined, a RAW at entry 1 gives stall until that entry reaches WB.
